// File: rtl/if_fetch_ctrl_pkg.sv
// RV32I_definitions: shared types and constants for the RV32I pipeline.
//   fetch_state_t    : IF-stage fetch sequencer states
//   NOP_INSTR        : canonical NOP (addi x0, x0, 0)
//   RESET_PC_DEFAULT : default program counter after reset
package RV32I_definitions;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_ctrl_redirect_arb.sv
// if_redirect_arb: combinational priority select between the EX branch and
// the ID jump redirect.
//   ID_Jump, ID_PC_dest                : jump resolved in ID
//   EX_PC_Branch, EX_PC_Branch_dest    : taken branch resolved in EX
//   Redirect                           : either redirect is active
//   Target                             : selected target, word aligned
//   Misaligned                         : selected target had [1:0] != 0
module if_redirect_arb
    import RV32I_definitions::*;
(
    input  logic        ID_Jump,
    input  logic [31:0] ID_PC_dest,
    input  logic        EX_PC_Branch,
    input  logic [31:0] EX_PC_Branch_dest,
    output logic        Redirect,
    output logic [31:0] Target,
    output logic        Misaligned
);

    logic [31:0] sel_dest;

    // EX holds the older instruction, so its branch wins over an ID jump.
    always_comb begin
        sel_dest   = ID_PC_dest;
        if (EX_PC_Branch) begin
            sel_dest = EX_PC_Branch_dest;
        end
        Redirect   = EX_PC_Branch | ID_Jump;
        Target     = {sel_dest[31:2], 2'b00};
        Misaligned = Redirect && (sel_dest[1:0] != 2'b00);
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage fetch sequencer. Owns the PC, drives the IMEM
// request/ack handshake, arbitrates redirects against hazard stalls and
// presents a valid-qualified instruction to IF/ID.
//   Clk, Reset (async, active high)
//   PC_Stall                          : hazard hold
//   ID_Jump/ID_PC_dest, EX_PC_Branch/EX_PC_Branch_dest : redirects
//   IMEM_Req, IMEM_Addr, IMEM_Ack, IMEM_RData         : IMEM port
//   IF_Valid, IF_Instr, IF_PC, IF_Flush, IF_Misaligned : IF/ID side
// Optional: define IF_FETCH_PERF_EN to add Perf_Fetched / Perf_Flushed.
module if_fetch_ctrl
    import RV32I_definitions::*;
#(
    parameter int          IMEM_ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       PC_Stall,
    input  logic                       ID_Jump,
    input  logic [31:0]                ID_PC_dest,
    input  logic                       EX_PC_Branch,
    input  logic [31:0]                EX_PC_Branch_dest,
    output logic                       IMEM_Req,
    output logic [IMEM_ADDR_WIDTH-1:0] IMEM_Addr,
    input  logic                       IMEM_Ack,
    input  logic [31:0]                IMEM_RData,
    output logic                       IF_Valid,
    output logic [31:0]                IF_Instr,
    output logic [31:0]                IF_PC,
    output logic                       IF_Flush,
    output logic                       IF_Misaligned
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]                Perf_Fetched,
    output logic [31:0]                Perf_Flushed
`endif
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pending_pc;
    logic [31:0]  hold_instr;
    logic [31:0]  hold_pc;

    logic         redirect;
    logic [31:0]  redirect_tgt;
    logic         redirect_misal;

    if_redirect_arb u_arb (
        .ID_Jump           (ID_Jump),
        .ID_PC_dest        (ID_PC_dest),
        .EX_PC_Branch      (EX_PC_Branch),
        .EX_PC_Branch_dest (EX_PC_Branch_dest),
        .Redirect          (redirect),
        .Target            (redirect_tgt),
        .Misaligned        (redirect_misal)
    );

    // Request is a pure decode of the state register; address stays on PC,
    // which only moves on an ack, so it is stable across wait states.
    assign IMEM_Req  = (state == FETCH) || (state == DRAIN);
    assign IMEM_Addr = pc[IMEM_ADDR_WIDTH+1:2];
    assign IF_Flush  = redirect && !Reset;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= BOOT;
            pc            <= RESET_PC;
            pending_pc    <= '0;
            hold_instr    <= NOP_INSTR;
            hold_pc       <= '0;
            IF_Valid      <= 1'b0;
            IF_Instr      <= NOP_INSTR;
            IF_PC         <= RESET_PC;
            IF_Misaligned <= 1'b0;
        end else begin
            if (redirect_misal) begin
                IF_Misaligned <= 1'b1;
            end
            case (state)
                BOOT: begin
                    IF_Valid <= 1'b0;
                    state    <= FETCH;
                    if (redirect) begin
                        pc <= redirect_tgt;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        IF_Valid <= 1'b0;
                        if (IMEM_Ack) begin
                            pc <= redirect_tgt;
                        end else begin
                            pending_pc <= redirect_tgt;
                            state      <= DRAIN;
                        end
                    end else if (IMEM_Ack) begin
                        pc <= pc + 32'd4;
                        if (PC_Stall) begin
                            hold_instr <= IMEM_RData;
                            hold_pc    <= pc;
                            state      <= HOLD;
                        end else begin
                            IF_Instr <= IMEM_RData;
                            IF_PC    <= pc;
                            IF_Valid <= 1'b1;
                        end
                    end else if (!PC_Stall) begin
                        IF_Valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc       <= redirect_tgt;
                        IF_Valid <= 1'b0;
                        state    <= FETCH;
                    end else if (!PC_Stall) begin
                        IF_Instr <= hold_instr;
                        IF_PC    <= hold_pc;
                        IF_Valid <= 1'b1;
                        state    <= FETCH;
                    end
                end
                DRAIN: begin
                    IF_Valid <= 1'b0;
                    // A redirect coinciding with the drain ack needs no
                    // further wait; the newest target wins either way.
                    if (IMEM_Ack) begin
                        pc    <= redirect ? redirect_tgt : pending_pc;
                        state <= FETCH;
                    end else if (redirect) begin
                        pending_pc <= redirect_tgt;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic deliver;

    assign deliver = !redirect && !PC_Stall &&
                     (((state == FETCH) && IMEM_Ack) || (state == HOLD));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Perf_Fetched <= '0;
            Perf_Flushed <= '0;
        end else begin
            if (deliver) begin
                Perf_Fetched <= Perf_Fetched + 32'd1;
            end
            if (IF_Flush) begin
                Perf_Flushed <= Perf_Flushed + 32'd1;
            end
        end
    end
`endif

endmodule
